// File: rtl/prim_clock_switch_pkg.sv
// -----------------------------------------------------------------------------
// prim_clock_switch_pkg
//
// Shared types and constants for the glitch-free clock switch sequencer.
//
// Contents:
//   CntW        width of the gate-off / settle down-counter
//   sw_state_e  sequencer state encoding (2 bits; 2'b11 is unused/illegal)
// -----------------------------------------------------------------------------
package prim_clock_switch_pkg;

    // Both delay parameters are limited to 1..255, so 8 bits always suffice.
    localparam int CntW = 8;

    // Sequencer states. The encoding is fixed so the state register can be
    // observed as a plain 2-bit value (busy_o and any external checker decode
    // it directly).
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GATE_OFF = 2'b01,
        SETTLE   = 2'b10
    } sw_state_e;

endpackage : prim_clock_switch_pkg

// File: rtl/prim_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// prim_clock_switch_ctrl
//
// Control-side sequencer for a two-input clock mux plus downstream clock gate.
// Runs on an always-on control clock. A switch request closes the gate, waits
// OffCycles, flips the mux select, waits SettleCycles, reopens the gate and
// acknowledges. The select therefore never changes while the gate is open.
//
// Parameters:
//   OffCycles     cycles between clk_en_o falling and sel_o changing (1..255)
//   SettleCycles  cycles between sel_o changing and clk_en_o rising (1..255)
//   ResetSel      value of sel_o during and after reset
//
// Ports:
//   clk_i      in   always-on control clock, rising edge
//   rst_i      in   synchronous active-high reset
//   req_i      in   single-cycle switch request pulse
//   sel_req_i  in   target select, sampled only when req_i is high
//   sel_o      out  registered select to the clock mux
//   clk_en_o   out  registered enable to the downstream clock gate
//   busy_o     out  high while a switch is in progress (state != IDLE)
//   ack_o      out  one-cycle completion pulse
//
// Handshake: req_i is a one-cycle pulse that is accepted only while busy_o is
// low (the FSM is in IDLE); a pulse seen while busy_o is high is dropped with
// no queueing and no ack. Every accepted request produces exactly one ack_o
// pulse: on the next edge if the target already matches sel_o, otherwise
// OffCycles+SettleCycles edges after acceptance. A new request may be issued
// in the same cycle ack_o is high, since the FSM is already back in IDLE.
// -----------------------------------------------------------------------------
module prim_clock_switch_ctrl
    import prim_clock_switch_pkg::*;
#(
    parameter int   OffCycles    = 4,
    parameter int   SettleCycles = 4,
    parameter logic ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic sel_req_i,
    output logic sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic ack_o
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter check. A zero delay would make the counter
    // preload underflow and the gate/select ordering would collapse.
    // -------------------------------------------------------------------------
    if (OffCycles < 1 || OffCycles > 255) begin : g_bad_off_cycles
        $fatal(1, "prim_clock_switch_ctrl: OffCycles must be in 1..255");
    end
    if (SettleCycles < 1 || SettleCycles > 255) begin : g_bad_settle_cycles
        $fatal(1, "prim_clock_switch_ctrl: SettleCycles must be in 1..255");
    end

    // State constants as plain vectors so the register can hold the illegal
    // encoding and the default branch can recover from it.
    localparam logic [1:0] StIdle    = IDLE;
    localparam logic [1:0] StGateOff = GATE_OFF;
    localparam logic [1:0] StSettle  = SETTLE;

    // Counter preloads: the counter counts down to zero inclusive, so a delay
    // of N cycles loads N-1.
    localparam logic [CntW-1:0] OffInit    = CntW'(OffCycles - 1);
    localparam logic [CntW-1:0] SettleInit = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] CntOne     = CntW'(1);

    logic [1:0]      state_q;
    logic [CntW-1:0] cnt_q;
    logic            target_q;
    logic            sel_q;
    logic            clk_en_q;
    logic            ack_q;

    // -------------------------------------------------------------------------
    // Sequencer. All outputs come straight from flops; nothing from the inputs
    // reaches an output combinationally.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            target_q <= ResetSel;
            sel_q    <= ResetSel;
            clk_en_q <= 1'b1;
            ack_q    <= 1'b0;
        end else begin
            // ack is a single-cycle pulse unless a branch below raises it.
            ack_q <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        if (sel_req_i == sel_q) begin
                            // Already on the requested source: nothing to gate.
                            ack_q <= 1'b1;
                        end else begin
                            target_q <= sel_req_i;
                            clk_en_q <= 1'b0;
                            cnt_q    <= OffInit;
                            state_q  <= StGateOff;
                        end
                    end
                end

                StGateOff: begin
                    // Gate is closed; give it OffCycles before touching sel.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        sel_q   <= target_q;
                        cnt_q   <= SettleInit;
                        state_q <= StSettle;
                    end
                end

                StSettle: begin
                    // New source selected; let it settle before reopening.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntOne;
                    end else begin
                        clk_en_q <= 1'b1;
                        ack_q    <= 1'b1;
                        state_q  <= StIdle;
                    end
                end

                default: begin
                    // Unreachable encoding: park in IDLE with the gate closed.
                    // The next accepted request or a reset restores normal
                    // operation; the select is left alone.
                    state_q  <= StIdle;
                    cnt_q    <= '0;
                    clk_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o    = sel_q;
    assign clk_en_o = clk_en_q;
    assign ack_o    = ack_q;
    assign busy_o   = (state_q != StIdle);

endmodule : prim_clock_switch_ctrl

// File: tb/tb_prim_clock_switch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prim_clock_switch_ctrl
//
// Two instances share one clock: dut_a with default delays (4/4) and dut_b
// with OffCycles=1, SettleCycles=1. Expected select values are pushed when a
// request that should be accepted is driven, and popped by a monitor on every
// ack_o pulse. The monitor also checks that sel_o only moves while the gate is
// closed (outside of reset).
// -----------------------------------------------------------------------------
module tb_prim_clock_switch_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, req_a, sel_req_a;
  logic sel_a, en_a, busy_a, ack_a;
  logic rst_b, req_b, sel_req_b;
  logic sel_b, en_b, busy_b, ack_b;

  prim_clock_switch_ctrl #(
    .OffCycles   (4),
    .SettleCycles(4),
    .ResetSel    (1'b0)
  ) dut_a (
    .clk_i    (clk),
    .rst_i    (rst_a),
    .req_i    (req_a),
    .sel_req_i(sel_req_a),
    .sel_o    (sel_a),
    .clk_en_o (en_a),
    .busy_o   (busy_a),
    .ack_o    (ack_a)
  );

  prim_clock_switch_ctrl #(
    .OffCycles   (1),
    .SettleCycles(1),
    .ResetSel    (1'b0)
  ) dut_b (
    .clk_i    (clk),
    .rst_i    (rst_b),
    .req_i    (req_b),
    .sel_req_i(sel_req_b),
    .sel_o    (sel_b),
    .clk_en_o (en_b),
    .busy_o   (busy_b),
    .ack_o    (ack_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checker
  // ---------------------------------------------------------------------------
  logic [0:0] exp_a_q[$];
  logic [0:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic s, input logic e,
                          input logic b, input logic a);
    check({tag, "_a_sel"}, sel_a, s);
    check({tag, "_a_en"}, en_a, e);
    check({tag, "_a_busy"}, busy_a, b);
    check({tag, "_a_ack"}, ack_a, a);
  endtask

  task automatic expect_b(input string tag, input logic s, input logic e,
                          input logic b, input logic a);
    check({tag, "_b_sel"}, sel_b, s);
    check({tag, "_b_en"}, en_b, e);
    check({tag, "_b_busy"}, busy_b, b);
    check({tag, "_b_ack"}, ack_b, a);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: one-cycle request pulse. When the request should be
  // accepted, the expected final select is queued before the edge.
  // ---------------------------------------------------------------------------
  task automatic pulse_a(input logic s, input bit accepted);
    req_a = 1'b1;
    sel_req_a = s;
    if (accepted) exp_a_q.push_back(s);
    tick();
    req_a = 1'b0;
    sel_req_a = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_b(input logic s, input bit accepted);
    req_b = 1'b1;
    sel_req_b = s;
    if (accepted) exp_b_q.push_back(s);
    tick();
    req_b = 1'b0;
    sel_req_b = 1'($urandom_range(0, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: ack -> scoreboard pop, and select-only-while-gated invariant.
  // ---------------------------------------------------------------------------
  logic prev_sel_a, prev_en_a, rst_s_a;
  logic prev_sel_b, prev_en_b, rst_s_b;

  always @(posedge clk) begin
    rst_s_a = rst_a;
    #1;
    if (!rst_s_a) begin
      if (ack_a) begin
        if (exp_a_q.size() == 0) check("a_ack_spurious", ack_a, 1'b0);
        else check("a_ack_sel", sel_a, exp_a_q.pop_front());
      end
      if (sel_a !== prev_sel_a) check("a_sel_gated", {prev_en_a, en_a}, 2'b00);
    end
    prev_sel_a = sel_a;
    prev_en_a  = en_a;
  end

  always @(posedge clk) begin
    rst_s_b = rst_b;
    #1;
    if (!rst_s_b) begin
      if (ack_b) begin
        if (exp_b_q.size() == 0) check("b_ack_spurious", ack_b, 1'b0);
        else check("b_ack_sel", sel_b, exp_b_q.pop_front());
      end
      if (sel_b !== prev_sel_b) check("b_sel_gated", {prev_en_b, en_b}, 2'b00);
    end
    prev_sel_b = sel_b;
    prev_en_b  = en_b;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic t;
    rst_a = 1'b1; req_a = 1'b0; sel_req_a = 1'b0;
    rst_b = 1'b1; req_b = 1'b0; sel_req_b = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Reset values, held steady for 10 cycles.
    expect_a("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_b("rst", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_a("rst_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 0 -> 1 switch with default delays: gate at E0, sel at E4, ack at E8.
    pulse_a(1'b1, 1'b1);
    expect_a("sw_e0", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_a("sw_gate", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_a("sw_e4", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 5; i < 8; i++) begin
      tick();
      expect_a("sw_settle", 1'b1, 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_a("sw_e8", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    expect_a("sw_e9", 1'b1, 1'b1, 1'b0, 1'b0);

    // Request for the current source: immediate ack, gate untouched.
    pulse_a(1'b1, 1'b1);
    expect_a("same", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    expect_a("same_e1", 1'b1, 1'b1, 1'b0, 1'b0);

    // Back to 0, then a 0 -> 1 switch with ignored requests at E2 and E6.
    pulse_a(1'b0, 1'b1);
    repeat (9) tick();
    expect_a("back0", 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_a(1'b1, 1'b1);           // E0
    tick();                        // E1
    pulse_a(1'b0, 1'b0);           // E2, dropped
    repeat (3) tick();             // E3..E5
    pulse_a(1'b0, 1'b0);           // E6, dropped
    tick();                        // E7
    tick();                        // E8
    expect_a("ign_e8", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    expect_a("ign_e9", 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset at E5 of a 0 -> 1 switch aborts to reset values, no ack.
    pulse_a(1'b0, 1'b1);
    repeat (9) tick();
    pulse_a(1'b1, 1'b1);           // E0
    repeat (4) tick();             // E4
    expect_a("abort_e4", 1'b1, 1'b0, 1'b1, 1'b0);
    rst_a = 1'b1;
    tick();                        // E5
    expect_a("abort_e5", 1'b0, 1'b1, 1'b0, 1'b0);
    exp_a_q.delete();
    rst_a = 1'b0;
    repeat (10) tick();
    expect_a("abort_after", 1'b0, 1'b1, 1'b0, 1'b0);

    // Random targets from IDLE; each completes within 9 edges.
    for (int i = 0; i < 8; i++) begin
      t = 1'($urandom_range(0, 1));
      pulse_a(t, 1'b1);
      repeat (9) tick();
      expect_a("rand_idle", t, 1'b1, 1'b0, 1'b0);
    end

    // 1/1 delays, second request issued in the ack cycle of the first.
    pulse_b(1'b1, 1'b1);           // E0
    expect_b("b2b_e0", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();                        // E1
    expect_b("b2b_e1", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();                        // E2: ack
    expect_b("b2b_e2", 1'b1, 1'b1, 1'b0, 1'b1);
    pulse_b(1'b0, 1'b1);           // E3: accepted
    expect_b("b2b_e3", 1'b1, 1'b0, 1'b1, 1'b0);
    tick();                        // E4
    expect_b("b2b_e4", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();                        // E5
    expect_b("b2b_e5", 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    expect_b("b2b_e6", 1'b0, 1'b1, 1'b0, 1'b0);

    // Every accepted request must have been acknowledged.
    repeat (3) tick();
    check("a_q_empty", exp_a_q.size(), 0);
    check("b_q_empty", exp_b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prim_clock_switch_ctrl
